// File: rtl/onehot_codec_pipe.sv
// onehot_codec_pipe: registered binary <-> one-hot converter with a per-item error flag
//   and a saturating error counter.
// Latency: 1 cycle from input transfer to out_valid; sustains one result per cycle.
// Backpressure: output register + one skid register; in_ready is a function of registered
//   state only and drops the cycle after the skid register fills.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   input handshake; in_mode selects encode (0) or decode (1)
//   bin_in, onehot_in   operands for encode and decode respectively
//   out_valid/out_ready output handshake; out_mode, onehot_out, bin_out, out_err form the result
//   err_count           saturating count of erroneous results delivered downstream
module onehot_codec_pipe #(
  parameter int BIN_WIDTH    = 4,
  parameter int ONEHOT_WIDTH = 16,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic [BIN_WIDTH-1:0]    bin_in,
  input  logic [ONEHOT_WIDTH-1:0] onehot_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_mode,
  output logic [ONEHOT_WIDTH-1:0] onehot_out,
  output logic [BIN_WIDTH-1:0]    bin_out,
  output logic                    out_err,
  output logic [CNT_WIDTH-1:0]    err_count
);

  // A one-hot vector wider than the binary code can address, or narrower than
  // two bits, has no meaningful mapping.
  generate
    if (ONEHOT_WIDTH < 2 || ONEHOT_WIDTH > (2 ** BIN_WIDTH)) begin : g_bad_width
      $error("onehot_codec_pipe: ONEHOT_WIDTH must be in 2 .. 2**BIN_WIDTH");
    end
  endgenerate

  typedef struct packed {
    logic                    mode;
    logic [ONEHOT_WIDTH-1:0] onehot;
    logic [BIN_WIDTH-1:0]    bin;
    logic                    err;
  } res_t;

  // ---------------------------------------------------------------------------
  // Combinational conversion of the presented input
  // ---------------------------------------------------------------------------
  logic [ONEHOT_WIDTH-1:0] enc_vec;
  logic [BIN_WIDTH-1:0]    dec_bin;
  logic                    dec_single;
  res_t                    res_new;

  always_comb begin
    enc_vec = '0;
    // Codes at or above ONEHOT_WIDTH match no bit, leaving enc_vec all-zero;
    // that all-zero vector doubles as the out-of-range indication.
    for (int i = 0; i < ONEHOT_WIDTH; i++) begin
      enc_vec[i] = (bin_in == BIN_WIDTH'(i));
    end
  end

  always_comb begin
    dec_bin = '0;
    // Scan from the top so the last hit, i.e. the lowest set bit, wins.
    for (int i = ONEHOT_WIDTH - 1; i >= 0; i--) begin
      if (onehot_in[i]) begin
        dec_bin = BIN_WIDTH'(i);
      end
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign dec_single = (onehot_in != '0) &&
                      ((onehot_in & (onehot_in - ONEHOT_WIDTH'(1))) == '0);

  always_comb begin
    res_new      = '0;
    res_new.mode = in_mode;
    if (!in_mode) begin
      res_new.onehot = enc_vec;
      res_new.bin    = bin_in;
      res_new.err    = ~|enc_vec;
    end else begin
      res_new.onehot = onehot_in;
      res_new.bin    = dec_bin;
      res_new.err    = ~dec_single;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register (OR) + skid register (SR)
  // ---------------------------------------------------------------------------
  logic                 or_vld_q, or_vld_d;
  res_t                 or_dat_q, or_dat_d;
  logic                 sr_vld_q, sr_vld_d;
  res_t                 sr_dat_q, sr_dat_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic in_xfer;
  logic out_xfer;

  // Readiness depends only on SR occupancy, never on out_ready.
  assign in_ready = !rst && !sr_vld_q;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = or_vld_q && out_ready;

  always_comb begin
    or_vld_d  = or_vld_q;
    or_dat_d  = or_dat_q;
    sr_vld_d  = sr_vld_q;
    sr_dat_d  = sr_dat_q;
    err_cnt_d = err_cnt_q;

    if (out_xfer) begin
      if (sr_vld_q) begin
        // SR holds the older item; no input can arrive while SR is full.
        or_dat_d = sr_dat_q;
        sr_vld_d = 1'b0;
      end else if (in_xfer) begin
        // Drain and refill in the same cycle keeps throughput at one per cycle.
        or_dat_d = res_new;
      end else begin
        // Data is left in place so the output fields stay deterministic.
        or_vld_d = 1'b0;
      end
    end else if (in_xfer) begin
      if (!or_vld_q) begin
        or_vld_d = 1'b1;
        or_dat_d = res_new;
      end else begin
        sr_vld_d = 1'b1;
        sr_dat_d = res_new;
      end
    end

    if (out_xfer && or_dat_q.err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      or_vld_q  <= 1'b0;
      or_dat_q  <= '0;
      sr_vld_q  <= 1'b0;
      sr_dat_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      or_vld_q  <= or_vld_d;
      or_dat_q  <= or_dat_d;
      sr_vld_q  <= sr_vld_d;
      sr_dat_q  <= sr_dat_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // out_valid is masked by rst so nothing is offered downstream during reset,
  // even in the cycle before the reset edge lands.
  assign out_valid  = or_vld_q && !rst;
  assign out_mode   = or_dat_q.mode;
  assign onehot_out = or_dat_q.onehot;
  assign bin_out    = or_dat_q.bin;
  assign out_err    = or_dat_q.err;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_onehot_codec_pipe.sv
module tb_onehot_codec_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Main instance: default parameters (4 / 16 / 8)
  logic        in_valid, in_ready, in_mode;
  logic [3:0]  bin_in;
  logic [15:0] onehot_in;
  logic        out_valid, out_ready, out_mode, out_err;
  logic [15:0] onehot_out;
  logic [3:0]  bin_out;
  logic [7:0]  err_count;

  // Small instance: 4 / 10 / 2 for out-of-range codes and counter saturation
  logic        s_in_valid, s_in_ready, s_in_mode;
  logic [3:0]  s_bin_in;
  logic [9:0]  s_onehot_in;
  logic        s_out_valid, s_out_ready, s_out_mode, s_out_err;
  logic [9:0]  s_onehot_out;
  logic [3:0]  s_bin_out;
  logic [1:0]  s_err_count;

  onehot_codec_pipe u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .bin_in(bin_in), .onehot_in(onehot_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
    .onehot_out(onehot_out), .bin_out(bin_out), .out_err(out_err),
    .err_count(err_count)
  );

  onehot_codec_pipe #(.BIN_WIDTH(4), .ONEHOT_WIDTH(10), .CNT_WIDTH(2)) u_small (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_mode(s_in_mode),
    .bin_in(s_bin_in), .onehot_in(s_onehot_in),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_mode(s_out_mode),
    .onehot_out(s_onehot_out), .bin_out(s_bin_out), .out_err(s_out_err),
    .err_count(s_err_count)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        mode;
    logic [3:0]  bin;
    logic [15:0] oh;
    logic [15:0] exp_oh;
    logic [3:0]  exp_bin;
    logic        exp_err;
  } vec_t;

  vec_t tbl[22];
  vec_t cur_exp;
  vec_t sb_q[$];
  vec_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: push on input transfer, pop and compare on output transfer.
  // Sampled at negedge, where the handshake equals what the next posedge sees.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: output onehot=0x%0h bin=%0d with no pending item",
                   onehot_out, bin_out);
        end else begin
          mon_e = sb_q.pop_front();
          chk("sb_mode",   32'(out_mode),   32'(mon_e.mode));
          chk("sb_onehot", 32'(onehot_out), 32'(mon_e.exp_oh));
          chk("sb_bin",    32'(bin_out),    32'(mon_e.exp_bin));
          chk("sb_err",    32'(out_err),    32'(mon_e.exp_err));
        end
      end
      if (in_valid && in_ready) sb_q.push_back(cur_exp);
    end
  end

  // Present one item on the main input; returns #1 after the accepting edge.
  task automatic send(input vec_t v);
    int  n;
    bit  acc;
    in_valid  = 1'b1;
    in_mode   = v.mode;
    bin_in    = v.bin;
    onehot_in = v.oh;
    cur_exp   = v;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    chk("send_accept", 32'(acc), 32'd1);
  endtask

  // One encode on the small instance, with its result and resulting counter.
  task automatic s_send(input logic [3:0] b, input logic [9:0] exp_oh,
                        input logic exp_err, input logic [1:0] exp_cnt);
    int n;
    bit acc;
    s_in_valid = 1'b1;
    s_bin_in   = b;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = s_in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    s_in_valid = 1'b0;
    chk("s_accept",    32'(acc),          32'd1);
    chk("s_out_valid", 32'(s_out_valid),  32'd1);
    chk("s_onehot",    32'(s_onehot_out), 32'(exp_oh));
    chk("s_err",       32'(s_out_err),    32'(exp_err));
    chk("s_bin_echo",  32'(s_bin_out),    32'(b));
    chk("s_mode",      32'(s_out_mode),   32'd0);
    @(posedge clk);
    #1;
    chk("s_err_count", 32'(s_err_count),  32'(exp_cnt));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int running;

    rst = 1'b1;
    in_valid = 1'b0; in_mode = 1'b0; bin_in = '0; onehot_in = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_mode = 1'b0; s_bin_in = '0; s_onehot_in = '0; s_out_ready = 1'b1;

    // Encode sweep entries, then decode cases.
    for (int i = 0; i < 16; i++) begin
      tbl[i].mode    = 1'b0;
      tbl[i].bin     = 4'(i);
      tbl[i].oh      = 16'h0000;
      tbl[i].exp_oh  = 16'h0001 << i;
      tbl[i].exp_bin = 4'(i);
      tbl[i].exp_err = 1'b0;
    end
    tbl[16] = '{1'b1, 4'd0, 16'h0040, 16'h0040, 4'd6,  1'b0};
    tbl[17] = '{1'b1, 4'd0, 16'h0000, 16'h0000, 4'd0,  1'b1};
    tbl[18] = '{1'b1, 4'd0, 16'h0024, 16'h0024, 4'd2,  1'b1};
    tbl[19] = '{1'b1, 4'd0, 16'h8000, 16'h8000, 4'd15, 1'b0};
    tbl[20] = '{1'b1, 4'd0, 16'h8001, 16'h8001, 4'd0,  1'b1};
    tbl[21] = '{1'b1, 4'd0, 16'hFFFF, 16'hFFFF, 4'd0,  1'b1};

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_in_ready",   32'(in_ready),   32'd0);
    chk("rst_err_count",  32'(err_count),  32'd0);
    chk("rst_onehot_out", 32'(onehot_out), 32'd0);
    chk("rst_bin_out",    32'(bin_out),    32'd0);
    chk("rst_out_mode",   32'(out_mode),   32'd0);
    chk("rst_out_err",    32'(out_err),    32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // ---------------- encode sweep, back to back ----------------
    running = 0;
    c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      send(tbl[i]);
      chk("sweep_out_valid", 32'(out_valid),  32'd1);
      chk("sweep_onehot",    32'(onehot_out), 32'(tbl[i].exp_oh));
      chk("sweep_err",       32'(out_err),    32'(tbl[i].exp_err));
      chk("sweep_err_count", 32'(err_count),  32'(running));
      running += int'(tbl[i].exp_err);
    end
    chk("sweep_cycles", 32'(cyc - c0), 32'd16);

    // ---------------- decode cases ----------------
    for (int i = 16; i < 22; i++) begin
      send(tbl[i]);
      chk("dec_out_valid", 32'(out_valid),  32'd1);
      chk("dec_mode",      32'(out_mode),   32'd1);
      chk("dec_bin",       32'(bin_out),    32'(tbl[i].exp_bin));
      chk("dec_onehot",    32'(onehot_out), 32'(tbl[i].exp_oh));
      chk("dec_err",       32'(out_err),    32'(tbl[i].exp_err));
      chk("dec_err_count", 32'(err_count),  32'(running));
      running += int'(tbl[i].exp_err);
    end
    @(posedge clk);
    #1;
    chk("dec_final_count", 32'(err_count), 32'(running));
    chk("dec_idle_valid",  32'(out_valid), 32'd0);

    // ---------------- backpressure ----------------
    out_ready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 4; k++) send(tbl[k]);
      end
      begin
        for (int k = 0; k < 4; k++) begin
          @(posedge clk);
          #1;
          chk("bp_out_valid", 32'(out_valid),  32'd1);
          chk("bp_hold",      32'(onehot_out), 32'h0002);
          chk("bp_in_ready",  32'(in_ready),   (k == 0) ? 32'd1 : 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_ready_back", 32'(in_ready),   32'd1);
        chk("bp_sr_to_or",   32'(onehot_out), 32'h0004);
      end
    join
    @(posedge clk);
    #1;
    chk("bp_drained",   32'(sb_q.size()), 32'd0);
    chk("bp_err_count", 32'(err_count),   32'(running));

    // ---------------- small instance: range and saturation ----------------
    s_send(4'd12, 10'h000, 1'b1, 2'd1);
    s_send(4'd9,  10'h200, 1'b0, 2'd1);
    s_send(4'd10, 10'h000, 1'b1, 2'd2);
    s_send(4'd15, 10'h000, 1'b1, 2'd3);
    s_send(4'd11, 10'h000, 1'b1, 2'd3);
    s_send(4'd13, 10'h000, 1'b1, 2'd3);

    // ---------------- mid-operation reset ----------------
    out_ready = 1'b0;
    send(tbl[7]);
    send(tbl[8]);
    chk("mr_sr_full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("mr_comb_in_ready",  32'(in_ready),  32'd0);
    chk("mr_comb_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("mr_out_valid", 32'(out_valid),  32'd0);
    chk("mr_err_count", 32'(err_count),  32'd0);
    chk("mr_in_ready",  32'(in_ready),   32'd0);
    chk("mr_onehot",    32'(onehot_out), 32'd0);
    chk("mr_bin",       32'(bin_out),    32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mr_ready_after", 32'(in_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("mr_no_stale", 32'(out_valid), 32'd0);
    end
    send(tbl[16]);
    chk("mr_new_bin",   32'(bin_out),   32'd6);
    chk("mr_new_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    chk("mr_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
